// File: rtl/ram_sync_clr.sv
// ram_sync_clr: parametrised synchronous single-port RAM.
// Has a registered read port with a one-cycle o_valid strobe, and a clear
// engine that zero-fills every word after reset or on request (busy while
// running).
//
// Handshake: there is no backpressure. r/w/clr are sampled at every rising
// edge while busy=0 and are ignored while busy=1. Every accepted read
// produces exactly one o_valid pulse, one cycle later, with o holding the
// read data. o keeps its last value whenever o_valid is low.
// The FSM state is visible on busy, which is high exactly when the FSM is in
// S_CLEAR.
module ram_sync_clr #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 8,
    parameter int AW         = 3,
    parameter int READ_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r,
    input  logic             w,
    input  logic             clr,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    output logic             busy
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             o_valid_q, o_valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             addr_ok;
    logic [WIDTH-1:0] rd_word;

    // Address range check and array read. Words beyond DEPTH read as zero.
    always_comb begin
        addr_ok = (32'(addr) < 32'(DEPTH));
        rd_word = '0;
        if (addr_ok) begin
            rd_word = mem[addr];
        end
    end

    // Next-state logic: the clear sweep, then normal read/write service.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        o_d       = o_q;
        o_valid_d = 1'b0;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = D;

        unique case (state_q)
            S_CLEAR: begin
                // One word is zeroed per cycle; the last word also releases busy.
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                if (ptr_q == LAST_WORD) begin
                    state_d = S_READY;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            S_READY: begin
                if (clr) begin
                    // clr wins over any r/w in the same cycle.
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    // Out-of-range writes are dropped.
                    mem_we = w && addr_ok;
                    if (r) begin
                        o_valid_d = 1'b1;
                        if (!addr_ok) begin
                            o_d = '0;
                        end else if (READ_FIRST == 0 && w) begin
                            o_d = D;
                        end else begin
                            o_d = rd_word;
                        end
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase

        // Reset leaves the array alone in the cycle it is sampled.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    // Control and output registers with synchronous reset into the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            ptr_q     <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            busy_q    <= busy_d;
        end
    end

    // Storage array: single write port, no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign o       = o_q;
    assign o_valid = o_valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_ram_sync_clr.sv
// Bench for ram_sync_clr. Three instances: A (16x8, read-first), B (16x8,
// write-first) sharing A's inputs, and C (8-bit x 6 words in a 3-bit address
// space) with its own inputs. Each issued read pushes its expected word into
// that instance's queue; a monitor per instance pops and compares on o_valid.
module tb_ram_sync_clr;

  logic        clk;
  logic        rst;

  logic        ab_r, ab_w, ab_clr;
  logic [2:0]  ab_addr;
  logic [15:0] ab_d;
  logic [15:0] a_o, b_o;
  logic        a_v, b_v, a_busy, b_busy;

  logic        c_r, c_w, c_clr;
  logic [2:0]  c_addr;
  logic [7:0]  c_d;
  logic [7:0]  c_o;
  logic        c_v, c_busy;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [7:0]  exp_c[$];

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_sync_clr #(.WIDTH(16), .DEPTH(8), .AW(3), .READ_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .r(ab_r), .w(ab_w), .clr(ab_clr), .addr(ab_addr),
    .D(ab_d), .o(a_o), .o_valid(a_v), .busy(a_busy)
  );

  ram_sync_clr #(.WIDTH(16), .DEPTH(8), .AW(3), .READ_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .r(ab_r), .w(ab_w), .clr(ab_clr), .addr(ab_addr),
    .D(ab_d), .o(b_o), .o_valid(b_v), .busy(b_busy)
  );

  ram_sync_clr #(.WIDTH(8), .DEPTH(6), .AW(3), .READ_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .r(c_r), .w(c_w), .clr(c_clr), .addr(c_addr),
    .D(c_d), .o(c_o), .o_valid(c_v), .busy(c_busy)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (a_v === 1'b1) begin
      if (exp_a.size() == 0) chk("a_unexpected_valid", 32'd1, 32'd0);
      else chk("a_read", 32'(a_o), 32'(exp_a.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (b_v === 1'b1) begin
      if (exp_b.size() == 0) chk("b_unexpected_valid", 32'd1, 32'd0);
      else chk("b_read", 32'(b_o), 32'(exp_b.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (c_v === 1'b1) begin
      if (exp_c.size() == 0) chk("c_unexpected_valid", 32'd1, 32'd0);
      else chk("c_read", 32'(c_o), 32'(exp_c.pop_front()));
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic ab_op(input logic r, input logic w, input logic clr,
                       input logic [2:0] addr, input logic [15:0] d);
    ab_r = r; ab_w = w; ab_clr = clr; ab_addr = addr; ab_d = d;
    @(negedge clk);
    ab_r = 1'b0; ab_w = 1'b0; ab_clr = 1'b0;
  endtask

  task automatic ab_read(input logic [2:0] addr, input logic [15:0] ea, input logic [15:0] eb);
    exp_a.push_back(ea);
    exp_b.push_back(eb);
    ab_op(1'b1, 1'b0, 1'b0, addr, 16'h0);
  endtask

  task automatic c_op(input logic r, input logic w, input logic [2:0] addr, input logic [7:0] d);
    c_r = r; c_w = w; c_clr = 1'b0; c_addr = addr; c_d = d;
    @(negedge clk);
    c_r = 1'b0; c_w = 1'b0;
  endtask

  // Counts falling edges with busy high until it drops (bounded).
  task automatic count_busy(output int ca, output int cc);
    ca = 0;
    cc = 0;
    for (int k = 0; k < 20; k++) begin
      if (a_busy) ca++;
      if (c_busy) cc++;
      if (!a_busy && !c_busy) break;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ca, cc;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    ab_r = 0; ab_w = 0; ab_clr = 0; ab_addr = '0; ab_d = '0;
    c_r = 0; c_w = 0; c_clr = 0; c_addr = '0; c_d = '0;

    // Test 1: reset state, clear length, array reads zero.
    @(negedge clk);
    chk("rst_o_a", 32'(a_o), 32'h0);
    chk("rst_valid_a", 32'(a_v), 32'h0);
    chk("rst_busy_a", 32'(a_busy), 32'h1);
    chk("rst_busy_c", 32'(c_busy), 32'h1);
    rst = 1'b0;
    count_busy(ca, cc);
    chk("clear_len_a", 32'(ca), 32'd8);
    chk("clear_len_c", 32'(cc), 32'd6);
    for (int i = 0; i < 8; i++) ab_read(3'(i), 16'h0, 16'h0);
    ab_op(0, 0, 0, 3'd0, 16'h0);

    // Test 2: write then read back-to-back; idle cycle holds o.
    ab_op(0, 1, 0, 3'd3, 16'hA5A5);
    ab_read(3'd3, 16'hA5A5, 16'hA5A5);
    ab_op(0, 0, 0, 3'd0, 16'h0);
    chk("idle_valid_a", 32'(a_v), 32'h0);
    chk("idle_hold_a", 32'(a_o), 32'hA5A5);

    // Test 3: same-address read+write ordering.
    ab_op(0, 1, 0, 3'd5, 16'h1111);
    exp_a.push_back(16'h1111);
    exp_b.push_back(16'h2222);
    ab_op(1, 1, 0, 3'd5, 16'h2222);
    ab_read(3'd5, 16'h2222, 16'h2222);

    // Test 4: fill, then clr together with r/w; all words clear.
    for (int i = 0; i < 8; i++) ab_op(0, 1, 0, 3'(i), 16'(16'h1000 + i * 257));
    ab_read(3'd6, 16'h1606, 16'h1606);
    ab_read(3'd2, 16'h1202, 16'h1202);
    ab_op(1, 1, 1, 3'd2, 16'hFFFF);
    chk("clr_busy_a", 32'(a_busy), 32'h1);
    chk("clr_no_valid_a", 32'(a_v), 32'h0);
    ab_r = 1'b1; ab_w = 1'b1; ab_addr = 3'd4; ab_d = 16'hDEAD;
    count_busy(ca, cc);
    ab_r = 1'b0; ab_w = 1'b0;
    chk("clr_len_a", 32'(ca), 32'd8);
    for (int i = 0; i < 8; i++) ab_read(3'(i), 16'h0, 16'h0);

    // Test 6: out-of-range access on the 6-word instance.
    for (int i = 0; i < 6; i++) c_op(0, 1, 3'(i), 8'(8'h10 + i));
    c_op(0, 1, 3'd7, 8'h3C);
    exp_c.push_back(8'h00);
    c_op(1, 0, 3'd7, 8'h0);
    exp_c.push_back(8'h00);
    c_op(1, 0, 3'd6, 8'h0);
    for (int i = 0; i < 6; i++) begin
      exp_c.push_back(8'(8'h10 + i));
      c_op(1, 0, 3'(i), 8'h0);
    end
    c_op(0, 0, 3'd0, 8'h0);

    // Test 5: reset in the middle of a clear restarts it from word 0.
    ab_op(0, 1, 0, 3'd1, 16'hBEEF);
    ab_read(3'd1, 16'hBEEF, 16'hBEEF);
    ab_op(0, 0, 1, 3'd0, 16'h0);
    for (int i = 0; i < 3; i++) ab_op(0, 0, 0, 3'd0, 16'h0);
    chk("midclr_busy_a", 32'(a_busy), 32'h1);
    chk("midclr_hold_a", 32'(a_o), 32'hBEEF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_o_a", 32'(a_o), 32'h0);
    chk("rst2_o_b", 32'(b_o), 32'h0);
    count_busy(ca, cc);
    chk("rst2_len_a", 32'(ca), 32'd8);
    chk("rst2_len_c", 32'(cc), 32'd6);
    ab_read(3'd1, 16'h0, 16'h0);
    ab_read(3'd7, 16'h0, 16'h0);

    // Drain and report.
    ab_op(0, 0, 0, 3'd0, 16'h0);
    ab_op(0, 0, 0, 3'd0, 16'h0);
    chk("drain_a", 32'(exp_a.size()), 32'd0);
    chk("drain_b", 32'(exp_b.size()), 32'd0);
    chk("drain_c", 32'(exp_c.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
